// File: rtl/nonogram_pkg.sv
// Shared definitions for the nonogram solution serializer.
// Board limits, frame start marker, FSM state type, derived widths and
// the bytes-per-row helper used by the serializer and its row packer.
package nonogram_pkg;

  localparam int MAX_ROWS = 11;
  localparam int MAX_COLS = 11;
  localparam logic [7:0] START_BYTE = 8'hA5;

  localparam int N_CELLS = MAX_ROWS * MAX_COLS;
  localparam int ROW_W   = $clog2(MAX_ROWS);
  localparam int COL_W   = $clog2(MAX_COLS);
  localparam int IDX_W   = $clog2(N_CELLS);

  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(MAX_ROWS);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(MAX_COLS);
  localparam logic [ROW_W-1:0] ROW_ONE  = {{(ROW_W-1){1'b0}}, 1'b1};
  localparam logic [COL_W-1:0] COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    ROW  = 3'd2,
    UNK  = 3'd3,
    CSUM = 3'd4
  } state_t;

  // ceil(n/8): number of packed bytes needed for one board row
  function automatic logic [COL_W-1:0] bytes_per_row(input logic [COL_W-1:0] n);
    logic [COL_W:0] sum;
    sum = {1'b0, n} + {{(COL_W-2){1'b0}}, 3'd7};
    return {2'b00, sum[COL_W:3]};
  endfunction

endpackage

// File: rtl/row_byte_packer.sv
// Combinational packer for one 8-column slice of a board row.
// Inputs : assigned/known cell planes (cell (r,c) at bit r*MAX_COLS+c),
//          row index r, byte index j within the row, column count n.
// Outputs: data_byte - bit k = assigned & known of column 8j+k (0 if column >= n)
//          unk_cnt   - number of unknown cells among the valid columns of the slice
module row_byte_packer
  import nonogram_pkg::*;
(
  input  logic [N_CELLS-1:0] assigned,
  input  logic [N_CELLS-1:0] known,
  input  logic [ROW_W-1:0]   r,
  input  logic [COL_W-1:0]   j,
  input  logic [COL_W-1:0]   n,
  output logic [7:0]         data_byte,
  output logic [3:0]         unk_cnt
);

  // Pack the slice and count its unknown cells, masking columns beyond n
  always_comb begin
    data_byte = 8'h00;
    unk_cnt   = 4'd0;
    for (int k = 0; k < 8; k++) begin
      int col;
      int idx;
      col = (32'sd8 * int'(j)) + k;
      idx = (int'(r) * MAX_COLS) + col;
      if ((col < int'(n)) && (idx < N_CELLS)) begin
        data_byte[k] = assigned[idx[IDX_W-1:0]] & known[idx[IDX_W-1:0]];
        unk_cnt      = unk_cnt + {3'b000, ~known[idx[IDX_W-1:0]]};
      end else begin
        data_byte[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/solution_serializer.sv
// Framed byte-stream transmitter for a solved nonogram board.
// Latches the board on valid_in and sends, one byte per send/tx_done
// handshake: START_BYTE, m, n, packed row bytes, unknown count, XOR checksum.
// Ports: clk_50mhz, rst (sync, active-high), valid_in, assigned, known, m, n,
//        tx_done in; send, byte_out, busy, done out (all registered).
module solution_serializer
  import nonogram_pkg::*;
(
  input  logic               clk_50mhz,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [N_CELLS-1:0] assigned,
  input  logic [N_CELLS-1:0] known,
  input  logic [ROW_W-1:0]   m,
  input  logic [COL_W-1:0]   n,
  input  logic               tx_done,
  output logic               send,
  output logic [7:0]         byte_out,
  output logic               busy,
  output logic               done
);

  state_t             state_q, state_d;
  logic               wait_q, wait_d;
  logic [1:0]         idx_q, idx_d;
  logic [ROW_W-1:0]   r_q, r_d;
  logic [COL_W-1:0]   j_q, j_d;
  logic [N_CELLS-1:0] assigned_q, assigned_d;
  logic [N_CELLS-1:0] known_q, known_d;
  logic [ROW_W-1:0]   m_q, m_d;
  logic [COL_W-1:0]   n_q, n_d;
  logic [7:0]         csum_q, csum_d;
  logic [7:0]         unk_q, unk_d;
  logic               send_q, send_d;
  logic [7:0]         byte_q, byte_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               advance_s;
  logic               last_j_s;
  logic               last_r_s;
  logic [COL_W-1:0]   bpr_s;
  logic [ROW_W-1:0]   r_nx_s;
  logic [COL_W-1:0]   j_nx_s;
  logic [7:0]         pack_byte_s;
  logic [3:0]         pack_unk_s;

  // The packer looks at the position of the byte about to be issued, so the
  // next byte is ready in the tx_done cycle and send follows one cycle later.
  row_byte_packer u_packer (
    .assigned  (assigned_q),
    .known     (known_q),
    .r         (r_nx_s),
    .j         (j_nx_s),
    .n         (n_q),
    .data_byte (pack_byte_s),
    .unk_cnt   (pack_unk_s)
  );

  // Handshake qualifier and next row/byte position
  always_comb begin
    bpr_s     = bytes_per_row(n_q);
    last_j_s  = (j_q == (bpr_s - COL_ONE));
    last_r_s  = (r_q == (m_q - ROW_ONE));
    advance_s = wait_q & tx_done & (state_q != IDLE);
    r_nx_s    = r_q;
    j_nx_s    = j_q;
    if (state_q == HDR) begin
      r_nx_s = ROW_ZERO;
      j_nx_s = COL_ZERO;
    end else if ((state_q == ROW) && !last_j_s) begin
      j_nx_s = j_q + COL_ONE;
    end else if ((state_q == ROW) && !last_r_s) begin
      r_nx_s = r_q + ROW_ONE;
      j_nx_s = COL_ZERO;
    end else begin
      r_nx_s = r_q;
      j_nx_s = j_q;
    end
  end

  // Next-state, capture, accumulation and output decode
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    r_d        = r_q;
    j_d        = j_q;
    assigned_d = assigned_q;
    known_d    = known_q;
    m_d        = m_q;
    n_d        = n_q;
    csum_d     = csum_q;
    unk_d      = unk_q;
    byte_d     = byte_q;
    busy_d     = busy_q;
    send_d     = 1'b0;
    done_d     = 1'b0;
    // the send cycle itself is not a wait cycle; waiting starts right after
    wait_d     = wait_q | send_q;
    case (state_q)
      IDLE: begin
        // the cycle showing done is still closing the previous frame
        if (valid_in && !done_q) begin
          assigned_d = assigned;
          known_d    = known;
          m_d        = (m > ROW_MAX) ? ROW_MAX : m;
          n_d        = (n > COL_MAX) ? COL_MAX : n;
          idx_d      = 2'd0;
          r_d        = ROW_ZERO;
          j_d        = COL_ZERO;
          unk_d      = 8'h00;
          csum_d     = START_BYTE;
          byte_d     = START_BYTE;
          send_d     = 1'b1;
          busy_d     = 1'b1;
          wait_d     = 1'b0;
          state_d    = HDR;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        if (advance_s) begin
          wait_d = 1'b0;
          send_d = 1'b1;
          case (idx_q)
            2'd0: begin
              idx_d  = 2'd1;
              byte_d = {{(8-ROW_W){1'b0}}, m_q};
              csum_d = csum_q ^ {{(8-ROW_W){1'b0}}, m_q};
            end
            2'd1: begin
              idx_d  = 2'd2;
              byte_d = {{(8-COL_W){1'b0}}, n_q};
              csum_d = csum_q ^ {{(8-COL_W){1'b0}}, n_q};
            end
            default: begin
              if ((m_q != ROW_ZERO) && (n_q != COL_ZERO)) begin
                state_d = ROW;
                r_d     = r_nx_s;
                j_d     = j_nx_s;
                byte_d  = pack_byte_s;
                csum_d  = csum_q ^ pack_byte_s;
                unk_d   = unk_q + {4'h0, pack_unk_s};
              end else begin
                state_d = UNK;
                byte_d  = unk_q;
                csum_d  = csum_q ^ unk_q;
              end
            end
          endcase
        end else begin
          state_d = HDR;
        end
      end
      ROW: begin
        if (advance_s) begin
          wait_d = 1'b0;
          send_d = 1'b1;
          if (!last_j_s || !last_r_s) begin
            r_d    = r_nx_s;
            j_d    = j_nx_s;
            byte_d = pack_byte_s;
            csum_d = csum_q ^ pack_byte_s;
            unk_d  = unk_q + {4'h0, pack_unk_s};
          end else begin
            state_d = UNK;
            byte_d  = unk_q;
            csum_d  = csum_q ^ unk_q;
          end
        end else begin
          state_d = ROW;
        end
      end
      UNK: begin
        if (advance_s) begin
          wait_d  = 1'b0;
          send_d  = 1'b1;
          state_d = CSUM;
          byte_d  = csum_q;
          csum_d  = 8'h00;
        end else begin
          state_d = UNK;
        end
      end
      CSUM: begin
        if (advance_s) begin
          wait_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = CSUM;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= 1'b0;
      idx_q      <= 2'd0;
      r_q        <= ROW_ZERO;
      j_q        <= COL_ZERO;
      assigned_q <= {N_CELLS{1'b0}};
      known_q    <= {N_CELLS{1'b0}};
      m_q        <= ROW_ZERO;
      n_q        <= COL_ZERO;
      csum_q     <= 8'h00;
      unk_q      <= 8'h00;
      send_q     <= 1'b0;
      byte_q     <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      idx_q      <= idx_d;
      r_q        <= r_d;
      j_q        <= j_d;
      assigned_q <= assigned_d;
      known_q    <= known_d;
      m_q        <= m_d;
      n_q        <= n_d;
      csum_q     <= csum_d;
      unk_q      <= unk_d;
      send_q     <= send_d;
      byte_q     <= byte_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign send     = send_q;
  assign byte_out = byte_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_solution_serializer.sv
// Self-checking bench for solution_serializer: a frame-level reference model
// (byte queue built from the frame rules) is compared against the DUT on
// every cycle; literal frames pin the model for the documented examples.
module tb_solution_serializer;

  logic         clk_50mhz = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [120:0] assigned;
  logic [120:0] known;
  logic [3:0]   m;
  logic [3:0]   n;
  logic         tx_done;
  logic         send;
  logic [7:0]   byte_out;
  logic         busy;
  logic         done;

  logic resp_td = 1'b0;
  logic spur_td = 1'b0;
  assign tx_done = resp_td | spur_td;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int sends_seen = 0;
  int dones_seen = 0;

  logic [7:0] litq[$];

  solution_serializer dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .valid_in  (valid_in),
    .assigned  (assigned),
    .known     (known),
    .m         (m),
    .n         (n),
    .tx_done   (tx_done),
    .send      (send),
    .byte_out  (byte_out),
    .busy      (busy),
    .done      (done)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference frame built directly from the frame rules
  function automatic int build_frame(input logic [120:0] a, input logic [120:0] kn,
                                     input int mi, input int ni,
                                     output logic [7:0] f [0:31]);
    int mm, nn, bpr, len, unk;
    logic [7:0] b, cs;
    for (int i = 0; i < 32; i++) f[i] = 8'h00;
    mm = (mi > 11) ? 11 : mi;
    nn = (ni > 11) ? 11 : ni;
    f[0] = 8'hA5;
    f[1] = 8'(mm);
    f[2] = 8'(nn);
    len = 3;
    bpr = (nn + 7) / 8;
    for (int r = 0; r < mm; r++) begin
      for (int j = 0; j < bpr; j++) begin
        b = 8'h00;
        for (int kk = 0; kk < 8; kk++) begin
          int c;
          c = 8 * j + kk;
          if (c < nn) b[kk] = a[r*11+c] & kn[r*11+c];
        end
        f[len] = b;
        len++;
      end
    end
    unk = 0;
    for (int r = 0; r < mm; r++)
      for (int c = 0; c < nn; c++)
        if (!kn[r*11+c]) unk++;
    f[len] = 8'(unk);
    len++;
    cs = 8'h00;
    for (int i = 0; i < len; i++) cs = cs ^ f[i];
    f[len] = cs;
    len++;
    return len;
  endfunction

  // Per-cycle reference model and comparison
  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] fbuf [0:31];
    logic e_send, e_busy, e_done, was_send, was_done, active, waiting;
    logic [7:0] e_byte;
    logic iv, itd, ir;
    logic [120:0] ia, ik;
    int im, inn, len;
    e_send = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_byte = 8'h00;
    active = 1'b0; waiting = 1'b0;
    forever begin
      @(posedge clk_50mhz);
      cyc++;
      iv = valid_in; itd = tx_done; ir = rst;
      ia = assigned; ik = known; im = int'(m); inn = int'(n);
      #1;
      was_send = e_send;
      was_done = e_done;
      if (ir) begin
        exp_q.delete();
        active = 1'b0; waiting = 1'b0;
        e_send = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_byte = 8'h00;
      end else begin
        e_send = 1'b0;
        e_done = 1'b0;
        if (!active) begin
          if (iv && !was_done) begin
            len = build_frame(ia, ik, im, inn, fbuf);
            for (int i = 0; i < len; i++) exp_q.push_back(fbuf[i]);
            e_byte = exp_q.pop_front();
            e_send = 1'b1; e_busy = 1'b1;
            active = 1'b1; waiting = 1'b0;
          end
        end else begin
          if (waiting && itd) begin
            waiting = 1'b0;
            if (exp_q.size() == 0) begin
              e_done = 1'b1; e_busy = 1'b0; active = 1'b0;
            end else begin
              e_byte = exp_q.pop_front();
              e_send = 1'b1;
            end
          end else if (was_send) begin
            waiting = 1'b1;
          end
        end
      end
      chk("send", {31'd0, send}, {31'd0, e_send});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("byte_out", {24'd0, byte_out}, {24'd0, e_byte});
      if (send === 1'b1) sends_seen++;
      if (done === 1'b1) dones_seen++;
    end
  end

  // UART stand-in: tx_done 1..4 cycles after each send
  initial begin
    forever begin
      @(negedge clk_50mhz);
      resp_td = 1'b0;
      if (send === 1'b1) begin
        repeat ($urandom_range(1, 4)) @(negedge clk_50mhz);
        resp_td = 1'b1;
      end
    end
  end

  task automatic pin(input string nm, input logic [120:0] a, input logic [120:0] kn,
                     input int mi, input int ni);
    logic [7:0] f [0:31];
    int len;
    len = build_frame(a, kn, mi, ni, f);
    chk({nm, "_len"}, 32'(len), 32'(litq.size()));
    for (int i = 0; i < litq.size() && i < 32; i++)
      chk(nm, {24'd0, f[i]}, {24'd0, litq[i]});
  endtask

  task automatic start_frame(input logic [120:0] a, input logic [120:0] kn,
                             input logic [3:0] mi, input logic [3:0] ni);
    @(negedge clk_50mhz);
    assigned = a; known = kn; m = mi; n = ni; valid_in = 1'b1;
    @(negedge clk_50mhz);
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (dones_seen < target && t < 3000) begin
      @(negedge clk_50mhz);
      t++;
    end
    chk("frame_done_in_time", 32'(dones_seen >= target), 32'd1);
  endtask

  logic [120:0] b1_a, b2_a, all_k, b2_k, ones;
  logic [127:0] r128a, r128k;

  initial begin
    int tgt, base, t;
    rst = 1'b1; valid_in = 1'b0; assigned = '0; known = '0; m = 4'd0; n = 4'd0;
    ones  = '1;
    all_k = ones;
    b1_a  = '0;
    b1_a[0] = 1'b1; b1_a[2] = 1'b1; b1_a[12] = 1'b1; b1_a[13] = 1'b1;
    b2_k  = all_k;
    b2_k[1] = 1'b0; b2_k[13] = 1'b0;

    litq = '{8'hA5, 8'h02, 8'h03, 8'h05, 8'h06, 8'h00, 8'hA7};
    pin("pin_m2n3", b1_a, all_k, 2, 3);
    litq = '{8'hA5, 8'h02, 8'h03, 8'h05, 8'h02, 8'h02, 8'hA1};
    pin("pin_m2n3_unk", b1_a, b2_k, 2, 3);
    litq = '{8'hA5, 8'h0B, 8'h0B};
    for (int i = 0; i < 11; i++) begin litq.push_back(8'hFF); litq.push_back(8'h07); end
    litq.push_back(8'h00); litq.push_back(8'h5D);
    pin("pin_full", ones, all_k, 11, 11);
    litq = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'hA0};
    pin("pin_m0", b1_a, all_k, 0, 5);

    repeat (3) @(negedge clk_50mhz);
    rst = 1'b0;
    repeat (2) @(negedge clk_50mhz);

    start_frame(b1_a, all_k, 4'd2, 4'd3);    wait_done(1);
    start_frame(b1_a, b2_k, 4'd2, 4'd3);     wait_done(2);
    start_frame(ones, all_k, 4'd11, 4'd11);  wait_done(3);
    start_frame(b1_a, all_k, 4'd0, 4'd5);    wait_done(4);

    // tx_done while idle must be ignored
    @(negedge clk_50mhz); spur_td = 1'b1;
    @(negedge clk_50mhz); spur_td = 1'b0;
    repeat (3) @(negedge clk_50mhz);

    // valid_in held with another board across the frame and its done cycle
    start_frame(b1_a, all_k, 4'd2, 4'd3);
    repeat (4) @(negedge clk_50mhz);
    assigned = ones; m = 4'd11; n = 4'd11; valid_in = 1'b1;
    tgt = dones_seen + 1;
    t = 0;
    while (dones_seen < tgt && t < 3000) begin @(negedge clk_50mhz); t++; end
    repeat (3) @(negedge clk_50mhz);
    valid_in = 1'b0;
    wait_done(tgt + 1);

    // reset in the middle of the row bytes, then a fresh frame
    start_frame(ones, all_k, 4'd11, 4'd11);
    base = sends_seen;
    t = 0;
    while (sends_seen < base + 6 && t < 3000) begin @(negedge clk_50mhz); t++; end
    chk("reached_row_phase", 32'(sends_seen >= base + 6), 32'd1);
    rst = 1'b1;
    @(negedge clk_50mhz);
    rst = 1'b0;
    tgt = dones_seen;
    repeat (10) @(negedge clk_50mhz);
    chk("no_done_after_abort", 32'(dones_seen), 32'(tgt));
    start_frame(b1_a, b2_k, 4'd2, 4'd3);
    wait_done(tgt + 1);

    // randomized boards, including oversize dimensions
    for (int i = 0; i < 25; i++) begin
      r128a = {$urandom, $urandom, $urandom, $urandom};
      r128k = {$urandom, $urandom, $urandom, $urandom};
      if (i % 4 == 0) r128k = r128k | {$urandom, $urandom, $urandom, $urandom};
      tgt = dones_seen + 1;
      start_frame(r128a[120:0], r128k[120:0], 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
      wait_done(tgt);
      repeat ($urandom_range(0, 3)) @(negedge clk_50mhz);
    end

    repeat (5) @(negedge clk_50mhz);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/solution_serializer.md
Name: solution_serializer

Overview:
Transmit-side counterpart of the parser. On a solver completion pulse it latches the solved board (assigned and known bit-planes plus dimensions). It emits a framed byte stream to uart_tx, one byte per send/done handshake. It sits between the solver and the UART transmitter and replaces the bare assembler path with a framed, checksummed format the host can validate.

Parameters:
MAX_ROWS, 11, maximum board rows; sets the width of m.
MAX_COLS, 11, maximum board columns; sets the width of n and the row stride in the cell vectors.
START_BYTE, 8'hA5, frame start marker.

Ports:
clk_50mhz  in  1  system clock
rst  in  1  reset, synchronous, active-high
valid_in  in  1  one-cycle pulse: board solved, inputs valid this cycle
assigned  in  MAX_ROWS*MAX_COLS  cell value; cell (r,c) at bit r*MAX_COLS+c
known  in  MAX_ROWS*MAX_COLS  cell determined flag, same indexing
m  in  $clog2(MAX_ROWS)  number of rows
n  in  $clog2(MAX_COLS)  number of columns
tx_done  in  1  pulse from uart_tx: current byte fully shifted out
send  out  1  one-cycle pulse: byte_out valid, start transmission
byte_out  out  8  byte to transmit; held stable until tx_done
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the final byte's tx_done

Behaviour:
- Reset values: send=0, byte_out=0, busy=0, done=0; state=IDLE; all counters and accumulators 0.
- Frame format, in order:
  - START_BYTE
  - m, zero-extended to 8 bits
  - n, zero-extended to 8 bits
  - for r = 0..m-1: ceil(n/8) row bytes; bit k of byte j = assigned & known of cell (r, 8j+k); bits with column >= n are 0
  - UNK byte: count of cells with known=0 inside the m x n window
  - CSUM byte: XOR of every preceding byte, START_BYTE included
- Capture: in IDLE, valid_in latches assigned, known, m, n; busy goes to 1 the next cycle.
  - m > MAX_ROWS is clamped to MAX_ROWS; same rule for n and MAX_COLS.
  - valid_in while busy is ignored; latched data is unchanged.
- Latency: first send is asserted the cycle after valid_in.
- Handshake:
  - Each byte is issued with a single-cycle send and byte_out set in the same cycle.
  - The FSM then waits for tx_done.
  - The next send is asserted the cycle after tx_done.
  - tx_done arriving in a non-wait cycle is ignored.
- States:
  - IDLE -> HDR on valid_in.
  - HDR: three bytes, tracked by a 2-bit index.
  - HDR -> ROW if m!=0 and n!=0; otherwise -> UNK.
  - ROW: row counter r and byte counter j; j wraps at ceil(n/8)-1 and increments r; after the last byte of row m-1 -> UNK.
  - UNK -> CSUM.
  - CSUM -> IDLE after its tx_done; done pulses that same cycle.
  - Wait-for-tx_done is a flag within each state, not a separate state.
- Accumulation:
  - The checksum register XORs in every byte at its send cycle.
  - The unknown counter adds popcount(~known) over the valid columns of the current row byte at its send cycle.
  - The counter is 8 bits wide and cannot overflow (max 121 with defaults).
- Reset mid-frame: next cycle returns to IDLE with all outputs at reset values; no done pulse.
- done and busy: busy drops in the same cycle done pulses. A valid_in arriving in the cycle done pulses is ignored; valid_in is accepted from the following cycle.

Decomposition:
- Package nonogram_pkg holds:
  - MAX_ROWS, MAX_COLS, START_BYTE;
  - state enum {IDLE, HDR, ROW, UNK, CSUM};
  - a function bytes_per_row(n) = (n+7)>>3.
- One combinational sub-module, row_byte_packer. It takes latched assigned/known, r, j and n, and returns:
  - the packed data byte;
  - the unknown popcount for those 8 columns, masked by column < n.
- The top FSM stays sequential only.

Test Plan:
- m=2, n=3; row0 assigned=101, row1=011 (c0 first); all known -> bytes A5 02 03 05 06 00 A7, then a single done pulse.
- Same board with known cleared at (0,1) and (1,2) -> A5 02 03 05 02 02 A1.
- m=11, n=11; all assigned and known -> 27 bytes: A5 0B 0B, then 11x(FF 07), then 00, 5D. Also check each send is exactly one cycle after the previous tx_done.
- m=0, n=5 -> A5 00 05 00 A0; no row bytes.
- Second valid_in while busy, with a different board -> output stream unchanged from the first board; only one done pulse.
- Assert rst during the row-byte phase, then issue a fresh valid_in -> send, busy and done are 0 the cycle after rst, no done pulse; the new frame starts with A5 and a correct checksum, with no residue from the aborted frame.
